tube_display_ctrl: RTL and testbench

TUBE_DISPLAY_CTRL -- requirements
Module: tube_display_ctrl

---
 rtl/tube_display_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_tube_display_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tube_display_ctrl.sv
// tube_display_ctrl: memory-mapped LED register plus an 8-digit multiplexed
// seven-segment display that shows a 32-bit value in hex or in decimal.
// Decimal values go through a shift-and-add-3 conversion, one shift per cycle.
module tube_display_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [13:0] LED_ADDR  = 14'h3C60,
  parameter logic [13:0] TUBE_ADDR = 14'h3C80,
  parameter logic [13:0] MODE_ADDR = 14'h3C84
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioWrite_i,
  input  logic [13:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [15:0] led_o,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_o,
  output logic        busy_o
);

  localparam int unsigned PRE_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [31:0] DEC_LIMIT   = 32'd100000000;
  localparam logic [7:0]  SEG_BLANK   = 8'hFF;
  localparam logic [7:0]  SEG_DASH    = 8'hBF;
  localparam logic [7:0]  SEG_ZERO    = 8'hC0;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_led, w_led_nxt;
  logic [31:0]     r_value, w_value_nxt;
  logic            r_mode, w_mode_nxt;
  logic [7:0][7:0] r_buf, w_buf_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [31:0]     r_shift, w_shift_nxt;
  logic [31:0]     r_bcd, w_bcd_nxt;
  logic [4:0]      r_cnt, w_cnt_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_busy;
  logic [7:0]      r_seg_en, r_seg;

  logic            w_wr_led, w_wr_tube, w_wr_mode;
  logic            w_dec_start, w_hex_load;
  logic [31:0]     w_src;
  logic [31:0]     w_bcd_adj;
  logic [63:0]     w_dd;
  logic [7:0][7:0] w_hex_buf, w_dec_buf;
  logic            w_lead;

  // Seven-segment encoding of one hex digit, active-low, dp off
  function automatic logic [7:0] hex_enc(input logic [3:0] d);
    case (d)
      4'h0: hex_enc = 8'hC0;  4'h1: hex_enc = 8'hF9;
      4'h2: hex_enc = 8'hA4;  4'h3: hex_enc = 8'hB0;
      4'h4: hex_enc = 8'h99;  4'h5: hex_enc = 8'h92;
      4'h6: hex_enc = 8'h82;  4'h7: hex_enc = 8'hF8;
      4'h8: hex_enc = 8'h80;  4'h9: hex_enc = 8'h90;
      4'hA: hex_enc = 8'h88;  4'hB: hex_enc = 8'h83;
      4'hC: hex_enc = 8'hC6;  4'hD: hex_enc = 8'hA1;
      4'hE: hex_enc = 8'h86;  default: hex_enc = 8'h8E;
    endcase
  endfunction

  // Next-state: register writes, conversion FSM, buffer load, scan prescaler
  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_value_nxt = r_value;
    w_mode_nxt  = r_mode;
    w_buf_nxt   = r_buf;
    w_pre_nxt   = r_pre;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_bcd_adj   = '0;
    w_hex_buf   = '0;
    w_dec_buf   = '0;
    w_lead      = 1'b1;

    w_wr_led    = ioWrite_i && (addr_i == LED_ADDR);
    w_wr_tube   = ioWrite_i && (addr_i == TUBE_ADDR);
    w_wr_mode   = ioWrite_i && (addr_i == MODE_ADDR);
    w_dec_start = (w_wr_tube && r_mode) || (w_wr_mode && wdata_i[0]);
    w_hex_load  = (w_wr_tube && !r_mode) || (w_wr_mode && !wdata_i[0]);
    w_src       = w_wr_tube ? wdata_i : r_value;

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift left
    for (int k = 0; k < 8; k++) begin
      w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                     : r_bcd[4*k +: 4];
    end
    w_dd = {w_bcd_adj, r_shift} << 1;

    // Decimal display image from the post-shift BCD, leading zeros blanked
    for (int k = 7; k >= 1; k--) begin
      if (r_ovf) begin
        w_dec_buf[k] = SEG_DASH;
      end else if (w_lead && (w_dd[32 + 4*k +: 4] == 4'd0)) begin
        w_dec_buf[k] = SEG_BLANK;
      end else begin
        w_lead       = 1'b0;
        w_dec_buf[k] = hex_enc(w_dd[32 + 4*k +: 4]);
      end
    end
    w_dec_buf[0] = r_ovf ? SEG_DASH : hex_enc(w_dd[35:32]);

    for (int k = 0; k < 8; k++) begin
      w_hex_buf[k] = hex_enc(w_src[4*k +: 4]);
    end

    if (r_state == S_CONV) begin
      w_bcd_nxt   = w_dd[63:32];
      w_shift_nxt = w_dd[31:0];
      w_cnt_nxt   = r_cnt + 5'd1;
      if ((r_cnt == 5'd31) && !w_dec_start) begin
        w_buf_nxt   = w_dec_buf;
        w_state_nxt = S_IDLE;
      end
    end

    if (w_wr_led)  w_led_nxt   = wdata_i[15:0];
    if (w_wr_tube) w_value_nxt = wdata_i;
    if (w_wr_mode) w_mode_nxt  = wdata_i[0];

    if (w_dec_start) begin
      w_state_nxt = S_CONV;
      w_shift_nxt = w_src;
      w_bcd_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = (w_src >= DEC_LIMIT);
    end
    if (w_hex_load) begin
      w_state_nxt = S_IDLE;
      w_buf_nxt   = w_hex_buf;
    end

    if (r_pre == PRE_LAST) begin
      w_pre_nxt = '0;
      w_idx_nxt = r_idx + 3'd1;
    end else begin
      w_pre_nxt = r_pre + PRE_W'(1);
    end
  end

  // State and registered outputs; display outputs track the post-edge digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_led    <= '0;
      r_value  <= '0;
      r_mode   <= 1'b0;
      r_buf    <= {8{SEG_ZERO}};
      r_pre    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_seg_en <= 8'hFE;
      r_seg    <= SEG_ZERO;
    end else begin
      r_state  <= w_state_nxt;
      r_led    <= w_led_nxt;
      r_value  <= w_value_nxt;
      r_mode   <= w_mode_nxt;
      r_buf    <= w_buf_nxt;
      r_pre    <= w_pre_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_bcd    <= w_bcd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= (w_state_nxt == S_CONV);
      r_seg_en <= ~(8'b1 << w_idx_nxt);
      r_seg    <= w_buf_nxt[w_idx_nxt];
    end
  end

  assign led_o    = r_led;
  assign seg_en_o = r_seg_en;
  assign seg_o    = r_seg;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_tube_display_ctrl.sv
// Bench for tube_display_ctrl: directed scenarios followed by random IO
// writes, every cycle compared against an arithmetic model of the display.
module tb_tube_display_ctrl;

  localparam int unsigned SD = 4;
  localparam logic [13:0] A_LED  = 14'h3C60;
  localparam logic [13:0] A_TUBE = 14'h3C80;
  localparam logic [13:0] A_MODE = 14'h3C84;
  localparam logic [13:0] A_BAD  = 14'h3C64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_wr = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] led;
  logic [7:0]  seg_en, seg;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  hex_tab [16];
  logic [7:0]  m_buf [8];
  logic [15:0] m_led;
  logic [31:0] m_val, m_op;
  bit          m_mode, m_busy;
  int          m_left;
  int unsigned m_edges;

  tube_display_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .ioWrite_i(io_wr), .addr_i(addr),
    .wdata_i(wdata), .led_o(led), .seg_en_o(seg_en), .seg_o(seg),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_val = '0; m_op = '0; m_mode = 0; m_busy = 0;
    m_left = 0; m_edges = 0;
    for (int k = 0; k < 8; k++) m_buf[k] = 8'hC0;
  endtask

  task automatic hex_fill(input logic [31:0] v);
    for (int k = 0; k < 8; k++) m_buf[k] = hex_tab[(v >> (4*k)) & 32'hF];
  endtask

  task automatic dec_fill(input logic [31:0] v);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      if (v >= 32'd100000000)             m_buf[k] = 8'hBF;
      else if (k > 0 && longint'(v) < p)  m_buf[k] = 8'hFF;
      else                                m_buf[k] = hex_tab[(longint'(v) / p) % 10];
      p = p * 10;
    end
  endtask

  // Model effect of one rising edge with the given bus inputs
  task automatic model_edge(input bit wr, input logic [13:0] a, input logic [31:0] d);
    bit wl, wt, wm, start, hexl;
    logic [31:0] src;
    wl = wr && (a == A_LED);
    wt = wr && (a == A_TUBE);
    wm = wr && (a == A_MODE);
    start = (wt && m_mode) || (wm && d[0]);
    hexl  = (wt && !m_mode) || (wm && !d[0]);
    src   = wt ? d : m_val;
    if (m_busy && !start) begin
      m_left--;
      if (m_left == 0) begin
        dec_fill(m_op);
        m_busy = 0;
      end
    end
    if (wl) m_led = d[15:0];
    if (wt) m_val = d;
    if (wm) m_mode = d[0];
    if (start) begin
      m_busy = 1; m_left = 32; m_op = src;
    end
    if (hexl) begin
      m_busy = 0;
      hex_fill(src);
    end
    m_edges++;
  endtask

  task automatic check_all(input string tag);
    int idx;
    logic [7:0] en;
    idx = int'((m_edges / SD) % 8);
    en = 8'h01;
    en = ~(en << idx);
    chk({tag, ".led"}, 32'(led), 32'(m_led));
    chk({tag, ".en"}, 32'(seg_en), 32'(en));
    chk({tag, ".seg"}, 32'(seg), 32'(m_buf[idx]));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
  endtask

  // One clock cycle with the given bus write, entered and left at posedge+1
  task automatic cyc(input bit wr, input logic [13:0] a, input logic [31:0] d);
    io_wr = wr; addr = a; wdata = d;
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    io_wr = 1'b0; addr = '0; wdata = '0;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async.en", 32'(seg_en), 32'h0000_00FE);
    chk("rst_async.seg", 32'(seg), 32'h0000_00C0);
    chk("rst_async.led", 32'(led), 32'h0);
    chk("rst_async.busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int op;
    logic [31:0] d;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst_n = 1'b1;

    // LED register, then a non-matching address and a strobe-less write
    cyc(1, A_LED, 32'h0001A5A5);
    chk("led_a5a5", 32'(led), 32'h0000A5A5);
    cyc(1, A_BAD, 32'hFFFF_FFFF);
    cyc(0, A_LED, 32'h0000_1234);
    chk("led_unchanged", 32'(led), 32'h0000A5A5);

    // Hex display and a full scan with wrap
    pulse_reset();
    cyc(1, A_TUBE, 32'h12345678);
    chk("hex_first_seg", 32'(seg), 32'h80);
    idle(40);

    // Decimal mode: converts the current value, then 1234
    cyc(1, A_MODE, 32'h1);
    idle(33);
    cyc(1, A_TUBE, 32'd1234);
    for (int i = 0; i < 31; i++) begin
      cyc(0, '0, '0);
      chk("busy_hold", 32'(busy), 32'h1);
    end
    cyc(0, '0, '0);
    chk("busy_drop", 32'(busy), 32'h0);
    idle(34);

    // Out-of-range dashes, then zero
    cyc(1, A_TUBE, 32'd100000000);
    idle(34);
    cyc(1, A_TUBE, 32'd0);
    idle(34);

    // Restart mid-conversion
    cyc(1, A_TUBE, 32'd555);
    idle(9);
    cyc(1, A_TUBE, 32'd98765);
    idle(34);

    // Hex mode select cancels a conversion
    cyc(1, A_TUBE, 32'd42);
    idle(5);
    cyc(1, A_MODE, 32'h0);
    chk("hex_cancel_busy", 32'(busy), 32'h0);
    idle(8);

    // Reset pulse mid-scan
    idle(3);
    pulse_reset();
    idle(6);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      op = int'($urandom_range(0, 11));
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: d = $urandom_range(0, 99999);
        default: d = $urandom_range(99999990, 100000010);
      endcase
      case (op)
        5:  cyc(1, A_LED, $urandom);
        6:  cyc(1, A_TUBE, d);
        7:  cyc(1, A_MODE, 32'($urandom_range(0, 1)));
        8:  cyc(1, A_BAD, d);
        9:  cyc(0, A_TUBE, d);
        10: if ($urandom_range(0, 30) == 0) pulse_reset(); else cyc(0, '0, '0);
        default: cyc(0, '0, '0);
      endcase
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
